// File: rtl/keypad_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_ctrl_pkg                                                      |
// | Shared types for the keypad entry controller: the FSM state enum,    |
// | the key-code width and type, and a counter-width helper.             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package keypad_ctrl_pkg;

  localparam int KEY_CODE_W = 4;

  typedef logic [KEY_CODE_W-1:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } key_state_t;

  // Bits needed for a saturating counter that must reach max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_event_fifo                                                       |
// | Register-based FIFO for accepted key codes. The head is presented    |
// | combinationally from registers; a push into a full FIFO succeeds     |
// | only when a pop happens in the same cycle, otherwise it is dropped   |
// | and flagged on drop.                                                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             drop
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_full = (c_ptr_w + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full);
  // A pop on an empty FIFO is ignored; a full FIFO still accepts a push
  // when the head leaves in the same cycle.
  assign w_pop   = pop & ~w_empty;
  assign w_push  = push & (~w_full | w_pop);
  assign drop    = push & w_full & ~w_pop;

  assign valid     = ~w_empty;
  assign head_data = w_empty ? '0 : r_mem[r_rd_ptr];

  // Storage, pointers (power-of-two depth, so they wrap naturally) and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_entry_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_entry_controller                                              |
// | Qualifies key presses from a keypad scanner (stable code held for    |
// | HOLD_MIN cycles), tracks release with RELEASE_MIN low cycles, keeps  |
// | the last two accepted digits and queues accepted codes in a FIFO.    |
// | Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module keypad_entry_controller
  import keypad_ctrl_pkg::*;
#(
  parameter int HOLD_MIN      = 4,
  parameter int RELEASE_MIN   = 4,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [KEY_CODE_W-1:0] key_code,
  input  logic                  key_held,
  output logic [KEY_CODE_W-1:0] ev_code,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [KEY_CODE_W-1:0] digit_new,
  output logic [KEY_CODE_W-1:0] digit_old,
  output logic                  key_event,
  output logic                  overflow
);

  // The shared counter only needs to reach the largest threshold in use.
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int c_max_ab    = (HOLD_MIN > RELEASE_MIN) ? HOLD_MIN : RELEASE_MIN;
  localparam int c_max_cd    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_cnt_limit = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
`else
  localparam int c_cnt_limit = (HOLD_MIN > RELEASE_MIN) ? HOLD_MIN : RELEASE_MIN;
`endif
  localparam int c_cnt_w = cnt_width(c_cnt_limit);

  // The entry cycle counts as the first sample, so the last sample index is N-1.
  localparam logic [c_cnt_w-1:0] c_hold_last    = c_cnt_w'(HOLD_MIN - 1);
  localparam logic [c_cnt_w-1:0] c_release_last = c_cnt_w'(RELEASE_MIN - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [c_cnt_w-1:0] c_delay        = c_cnt_w'(REPEAT_DELAY);
  localparam logic [c_cnt_w-1:0] c_period       = c_cnt_w'(REPEAT_PERIOD);
`endif

  key_state_t         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  key_code_t          r_latched;
  key_code_t          r_digit_new;
  key_code_t          r_digit_old;
  logic               r_key_event;
  logic               r_overflow;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic               r_repeating;
`endif

  logic [c_cnt_w-1:0] w_cnt_inc;
  logic               w_emit;
  logic               w_drop;

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  // Decide whether this cycle produces an event (acceptance or repeat).
  always_comb begin
    w_emit = 1'b0;
    case (r_state)
      QUALIFY: w_emit = key_held && (key_code == r_latched) && (w_cnt_inc >= c_hold_last);
`ifdef KEYPAD_AUTOREPEAT_EN
      HELD:    w_emit = key_held && (w_cnt_inc == (r_repeating ? c_period : c_delay));
`endif
      default: w_emit = 1'b0;
    endcase
  end

  // Press/release FSM with registered event, digit and overflow outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_latched   <= '0;
      r_digit_new <= '0;
      r_digit_old <= '0;
      r_key_event <= 1'b0;
      r_overflow  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_repeating <= 1'b0;
`endif
    end else begin
      r_key_event <= w_emit;
      if (w_emit) begin
        r_digit_old <= r_digit_new;
        r_digit_new <= r_latched;
      end
      if (w_drop) r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          if (key_held) begin
            r_state   <= QUALIFY;
            r_latched <= key_code;
            r_cnt     <= '0;
          end
        end
        QUALIFY: begin
          if (!key_held) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (key_code != r_latched) begin
            r_latched <= key_code;
            r_cnt     <= '0;
          end else if (w_emit) begin
            r_state <= HELD;
            r_cnt   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_repeating <= 1'b0;
`endif
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        HELD: begin
          // Code changes are ignored here; only the held level matters.
          if (!key_held) begin
            r_state <= RELEASE;
            r_cnt   <= '0;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (w_emit) begin
            r_cnt       <= '0;
            r_repeating <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
`endif
        end
        RELEASE: begin
          // A bounce back to held resumes the press without a new event.
          if (key_held) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (w_cnt_inc >= c_release_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_CODE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_emit),
    .push_data (r_latched),
    .pop       (ev_ready),
    .head_data (ev_code),
    .valid     (ev_valid),
    .drop      (w_drop)
  );

  assign digit_new = r_digit_new;
  assign digit_old = r_digit_old;
  assign key_event = r_key_event;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire
